// File: rtl/game_pkg.sv
// game_pkg: shared state encoding, digit widths and m:ss conversion for the air-hockey game.
package game_pkg;
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUNNING = 3'd1,
        ST_PAUSED  = 3'd2,
        ST_FREEZE  = 3'd3,
        ST_EXPIRED = 3'd4
    } state_t;
    localparam int MIN_W  = 4;
    localparam int TENS_W = 3;
    localparam int ONES_W = 4;
    localparam int MMSS_W = MIN_W + TENS_W + ONES_W;
    function automatic logic [MMSS_W-1:0] mmss(input int secs);
        return {MIN_W'(secs / 60), TENS_W'((secs % 60) / 10), ONES_W'(secs % 10)};
    endfunction
endpackage

// File: rtl/bcd_mmss_down.sv
// bcd_mmss_down: loadable m:ss BCD down-counter that holds at 0:00.
module bcd_mmss_down
    import game_pkg::*;
#(
    parameter logic [MMSS_W-1:0] RELOAD = mmss(180)
) (
    input  logic              clk,
    input  logic              load,
    input  logic              dec,
    output logic [MIN_W-1:0]  min_bcd,
    output logic [TENS_W-1:0] sec_tens,
    output logic [ONES_W-1:0] sec_ones,
    output logic              zero
);
    logic [MIN_W-1:0]  r_min;
    logic [TENS_W-1:0] r_tens;
    logic [ONES_W-1:0] r_ones;
    assign zero = {r_min, r_tens, r_ones} == '0;
    always_ff @(posedge clk) begin
        if (load) begin
            {r_min, r_tens, r_ones} <= RELOAD;
        end else if (dec && !zero) begin
            r_ones <= (r_ones == '0) ? ONES_W'(9) : r_ones - 1'b1;
            if (r_ones == '0) begin
                r_tens <= (r_tens == '0) ? TENS_W'(5) : r_tens - 1'b1;
                if (r_tens == '0) r_min <= r_min - 1'b1;
            end
        end
    end
    assign min_bcd  = r_min;
    assign sec_tens = r_tens;
    assign sec_ones = r_ones;
endmodule

// File: rtl/match_timer.sv
// match_timer: match phase FSM, BCD match clock, post-goal freeze and game-tick gating.
module match_timer
    import game_pkg::*;
#(
    parameter int MATCH_SECONDS  = 180,
    parameter int FREEZE_SECONDS = 3
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              sec_tick,
    input  logic              game_tick,
    input  logic              start,
    input  logic              pause,
    input  logic              goal,
    output logic [2:0]        state,
    output logic [MIN_W-1:0]  min_bcd,
    output logic [TENS_W-1:0] sec_tens,
    output logic [ONES_W-1:0] sec_ones,
    output logic              game_en,
    output logic              expired
);
    localparam logic [3:0] FRZ = 4'(FREEZE_SECONDS);
    state_t     r_state, w_next;
    logic [3:0] r_frz, w_frz_next;
    logic       r_game_en, r_expired;
    logic       w_load, w_dec, w_exp, w_zero, w_last;
    bcd_mmss_down #(.RELOAD(mmss(MATCH_SECONDS))) u_clock (
        .clk      (clk),
        .load     (clr | w_load),
        .dec      (w_dec),
        .min_bcd  (min_bcd),
        .sec_tens (sec_tens),
        .sec_ones (sec_ones),
        .zero     (w_zero)
    );
    // The tick taken at 0:01 is the one that expires the match.
    assign w_last = {min_bcd, sec_tens, sec_ones} == MMSS_W'(1);
    always_comb begin
        w_next     = r_state;
        w_frz_next = r_frz;
        w_load     = 1'b0;
        w_dec      = 1'b0;
        w_exp      = 1'b0;
        case (r_state)
            ST_IDLE: w_next = start ? ST_RUNNING : ST_IDLE;
            ST_RUNNING: begin
                if (start) begin
                    w_next = ST_IDLE;
                    w_load = 1'b1;
                end else if (!pause) begin
                    w_dec = sec_tick && !w_zero;
                    if (sec_tick && w_last) begin
                        w_next = ST_EXPIRED;
                        w_exp  = 1'b1;
                    end else if (goal) begin
                        w_next     = ST_FREEZE;
                        w_frz_next = FRZ;
                    end
                end else begin
                    w_next = ST_PAUSED;
                end
            end
            ST_PAUSED: begin
                w_load = start;
                w_next = start ? ST_IDLE : pause ? ST_RUNNING : ST_PAUSED;
            end
            ST_FREEZE: begin
                if (start || pause) begin
                    w_next     = start ? ST_IDLE : ST_PAUSED;
                    w_load     = start;
                    w_frz_next = '0;
                end else if (goal) begin
                    w_frz_next = FRZ;
                end else if (sec_tick) begin
                    w_frz_next = (r_frz == '0) ? '0 : r_frz - 1'b1;
                    w_next     = (r_frz <= 4'd1) ? ST_RUNNING : ST_FREEZE;
                end
            end
            ST_EXPIRED: begin
                w_load = start;
                w_next = start ? ST_IDLE : ST_EXPIRED;
            end
            default: w_next = ST_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state   <= ST_IDLE;
            r_frz     <= '0;
            r_game_en <= 1'b0;
            r_expired <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_frz     <= w_frz_next;
            r_game_en <= game_tick && (r_state == ST_RUNNING);
            r_expired <= w_exp;
        end
    end
    assign state   = r_state;
    assign game_en = r_game_en;
    assign expired = r_expired;
endmodule
